// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } bcd_state_e;

  // A nibble at or above ADJ_THRESH would pass 9 when doubled, so ADJ_ADD is added first
  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_ADD    = 4'd3;

  // ceil(w * log10(2)) in integer arithmetic: number of decimal digits for a w-bit value
  function automatic int unsigned bcd_digits_needed(input int unsigned w);
    return (w * 32'd30103 + 32'd99999) / 32'd100000;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational add-3 correction for one BCD nibble, applied before each shift.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  // Bias the nibble so the following doubling carries at 10 instead of 16
  always_comb begin
    nib_o = nib_i;
    if (nib_i >= ADJ_THRESH) begin
      nib_o = nib_i + ADJ_ADD;
    end
  end

endmodule

// File: rtl/binary_to_bcd_seq.sv
// Multi-cycle double-dabble binary-to-BCD converter, one input bit per clock,
// with valid/ready handshakes on both sides.
// Optional macro BCD_SIGNED_EN: treat bin_in as two's complement and report sign_out.
module binary_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow,
  output logic                  sign_out
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(BIN_W + 1);
  // With enough digits nothing can ever leave the top nibble
  localparam bit OvfPossible = (DIGITS < bcd_digits_needed(BIN_W));

  bcd_state_e        state_q, state_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic [BcdW-1:0]   bcd_adj;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              sign_q, sign_d;
  logic [BIN_W-1:0]  load_mag;
  logic              load_sign;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .nib_i (bcd_q[4*g +: 4]),
      .nib_o (bcd_adj[4*g +: 4])
    );
  end

  // Value loaded into the shift register on acceptance
  always_comb begin
`ifdef BCD_SIGNED_EN
    load_sign = bin_in[BIN_W-1];
    // -2^(BIN_W-1) negates to itself, which reads correctly as an unsigned magnitude
    load_mag  = load_sign ? -bin_in : bin_in;
`else
    load_sign = 1'b0;
    load_mag  = bin_in;
`endif
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    sign_d  = sign_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          bin_d   = load_mag;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          sign_d  = load_sign;
          cnt_d   = CntW'(BIN_W);
          state_d = StShift;
        end
      end
      StShift: begin
        bcd_d = {bcd_adj[BcdW-2:0], bin_q[BIN_W-1]};
        bin_d = {bin_q[BIN_W-2:0], 1'b0};
        if (OvfPossible && bcd_adj[BcdW-1]) begin
          ovf_d = 1'b1;
        end
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      sign_q  <= sign_d;
    end
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
  end

  assign bcd_out  = bcd_q;
  assign overflow = ovf_q;
  assign sign_out = sign_q;

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Directed bench: a 16-bit/5-digit instance and an 8-bit narrow instance
// (2 digits unsigned, 3 digits when BCD_SIGNED_EN is defined).
module tb_binary_to_bcd_seq;

`ifdef BCD_SIGNED_EN
  localparam int unsigned BDig = 3;
`else
  localparam int unsigned BDig = 2;
`endif

  logic clk = 1'b0;
  logic rst_n;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_ovf, a_sign;
  logic [15:0] a_bin;
  logic [19:0] a_bcd;

  logic              b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_ovf, b_sign;
  logic [7:0]        b_bin;
  logic [4*BDig-1:0] b_bcd;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  binary_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .bin_in    (a_bin),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .bcd_out   (a_bcd),
    .overflow  (a_ovf),
    .sign_out  (a_sign)
  );

  binary_to_bcd_seq #(.BIN_W(8), .DIGITS(BDig)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .bin_in    (b_bin),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .bcd_out   (b_bcd),
    .overflow  (b_ovf),
    .sign_out  (b_sign)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Convert on instance A; optionally hold out_ready low for `hold` cycles in DONE
  task automatic conv_a(input string tag, input logic [15:0] v, input logic [19:0] exp_bcd,
                        input logic exp_ovf, input logic exp_sign, input int hold);
    int n;
    a_in_valid = 1'b1;
    a_bin      = v;
    check({tag, "_in_ready"}, 32'(a_in_ready), 32'd1);
    tick();
    a_in_valid = 1'b0;
    n = 0;
    while (!a_out_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd16);
    check({tag, "_bcd"}, 32'(a_bcd), 32'(exp_bcd));
    check({tag, "_ovf"}, 32'(a_ovf), 32'(exp_ovf));
    check({tag, "_sign"}, 32'(a_sign), 32'(exp_sign));
    for (int i = 0; i < hold; i++) begin
      a_in_valid = 1'b1;
      a_bin      = 16'd777;
      tick();
      check({tag, "_hold_valid"}, 32'(a_out_valid), 32'd1);
      check({tag, "_hold_bcd"}, 32'(a_bcd), 32'(exp_bcd));
      check({tag, "_hold_in_ready"}, 32'(a_in_ready), 32'd0);
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    check({tag, "_rdy_before_release"}, 32'(a_in_ready), 32'd0);
    tick();
    a_out_ready = 1'b0;
    check({tag, "_idle_in_ready"}, 32'(a_in_ready), 32'd1);
    check({tag, "_idle_out_valid"}, 32'(a_out_valid), 32'd0);
  endtask

  task automatic conv_b(input string tag, input logic [7:0] v, input logic [11:0] exp_bcd,
                        input logic exp_ovf, input logic exp_sign);
    int n;
    b_in_valid = 1'b1;
    b_bin      = v;
    tick();
    b_in_valid = 1'b0;
    n = 0;
    while (!b_out_valid && n < 30) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd8);
    check({tag, "_bcd"}, 32'(b_bcd), 32'(exp_bcd));
    check({tag, "_ovf"}, 32'(b_ovf), 32'(exp_ovf));
    check({tag, "_sign"}, 32'(b_sign), 32'(exp_sign));
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    check({tag, "_idle"}, 32'(b_in_ready), 32'd1);
  endtask

  initial begin
    rst_n       = 1'b0;
    a_in_valid  = 1'b0;
    a_out_ready = 1'b0;
    a_bin       = '0;
    b_in_valid  = 1'b0;
    b_out_ready = 1'b0;
    b_bin       = '0;
    repeat (3) tick();
    check("rst_in_ready", 32'(a_in_ready), 32'd1);
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_bcd", 32'(a_bcd), 32'd0);
    check("rst_ovf", 32'(a_ovf), 32'd0);
    check("rst_sign", 32'(a_sign), 32'd0);
    rst_n = 1'b1;
    tick();

    conv_a("a_zero", 16'd0, 20'h00000, 1'b0, 1'b0, 0);
`ifdef BCD_SIGNED_EN
    conv_a("a_neg1", 16'hFFFF, 20'h00001, 1'b0, 1'b1, 0);
`else
    conv_a("a_max", 16'd65535, 20'h65535, 1'b0, 1'b0, 0);
`endif
    conv_a("a_29_hold", 16'd29, 20'h00029, 1'b0, 1'b0, 5);
    conv_a("a_9999", 16'd9999, 20'h09999, 1'b0, 1'b0, 0);

    // Reset during SHIFT discards the conversion
    a_in_valid = 1'b1;
    a_bin      = 16'd4321;
    tick();
    a_in_valid = 1'b0;
    repeat (6) tick();
    check("mid_pre_ready", 32'(a_in_ready), 32'd0);
    rst_n = 1'b0;
    tick();
    check("mid_rst_in_ready", 32'(a_in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(a_out_valid), 32'd0);
    check("mid_rst_bcd", 32'(a_bcd), 32'd0);
    check("mid_rst_ovf", 32'(a_ovf), 32'd0);
    rst_n = 1'b1;
    conv_a("a_1234", 16'd1234, 20'h01234, 1'b0, 1'b0, 0);

`ifdef BCD_SIGNED_EN
    conv_b("b_min", 8'h80, 12'h128, 1'b0, 1'b1);
    conv_b("b_neg1", 8'hFF, 12'h001, 1'b0, 1'b1);
    conv_b("b_zero", 8'h00, 12'h000, 1'b0, 1'b0);
    conv_b("b_99", 8'd99, 12'h099, 1'b0, 1'b0);
`else
    conv_b("b_255", 8'd255, 12'h055, 1'b1, 1'b0);
    conv_b("b_99", 8'd99, 12'h099, 1'b0, 1'b0);
    conv_b("b_100", 8'd100, 12'h000, 1'b1, 1'b0);
    conv_b("b_7", 8'd7, 12'h007, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/binary_to_bcd_seq.md
Name: binary_to_bcd_seq

Overview:
Parametrised, multi-cycle binary-to-BCD converter using the shift-and-add-3 (double-dabble) method. It processes one input bit per clock, which scales to wide inputs without a large lookup table. Valid/ready handshakes on input and output let it sit between a binary datapath (counters, ADC samples) and the display/formatting logic that drives BCD digits.

Parameters:
- BIN_W, 16, binary input width in bits (>= 2).
- DIGITS, 5, number of BCD output digits; the output is 4*DIGITS bits wide. It may be set below the count needed for full range; overflow is then flagged.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  bin_in is valid.
- in_ready  output  1  converter can accept a value.
- bin_in  input  BIN_W  binary value; unsigned unless BCD_SIGNED_EN is defined.
- out_valid  output  1  result is valid.
- out_ready  input  1  downstream accepts the result.
- bcd_out  output  4*DIGITS  packed BCD result; digit 0 (units) is in bits [3:0].
- overflow  output  1  value did not fit in DIGITS digits.
- sign_out  output  1  result is negative (BCD_SIGNED_EN only; otherwise tied 0).

Behaviour:
- FSM states:
  - IDLE: in_ready=1. When in_valid=1, capture bin_in into a shift register, clear the BCD accumulator and overflow, load bit counter = BIN_W, go to SHIFT.
  - SHIFT: in_ready=0. Each cycle:
    - add 3 to every BCD nibble that is >= 5;
    - shift {bcd, bin} left by one;
    - if the bit shifted out of the top nibble is 1, set overflow (sticky);
    - decrement the counter; when the counter reaches 1, go to DONE.
  - DONE: out_valid=1; bcd_out, overflow and sign_out are held stable. When out_ready=1, go to IDLE.
- Latency: if acceptance occurs on edge k, out_valid goes high after edge k+BIN_W. Throughput is one result per BIN_W+2 cycles at best.
- in_ready is high only in IDLE. No input is accepted while a conversion is in flight or a result is pending.
- When the value does not fit, bcd_out = value mod 10^DIGITS and overflow=1.
- Every nibble of bcd_out is always in the range 0..9.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
- Reset (rst_n=0 at a rising edge, in any state, including mid-SHIFT or DONE): state=IDLE, in_ready=1, out_valid=0, bcd_out=0, overflow=0, sign_out=0. Any in-flight conversion is discarded.
- Handshake rule: once out_valid is asserted, outputs must not change until out_ready is seen.

Optional Feature:
- Macro: BCD_SIGNED_EN.
- Defined:
  - bin_in is two's complement.
  - On acceptance, sign_out is captured from bin_in[BIN_W-1] and the magnitude (negated if negative, held in BIN_W bits) is converted.
  - -2^(BIN_W-1) converts to magnitude 2^(BIN_W-1).
  - Zero always gives sign_out=0.
- Not defined: bin_in is unsigned and sign_out is tied to 0.

Decomposition:
- Package bcd_pkg contains:
  - a state typedef enum (IDLE, SHIFT, DONE);
  - a constant function bcd_digits_needed(w), returning ceil(w*log10(2));
  - the nibble constants ADJ_THRESH=5 and ADJ_ADD=3.
- Sub-module bcd_digit_adj: combinational per-nibble add-3 adjust, instantiated DIGITS times in a generate loop.

Test Plan:
- BIN_W=16, DIGITS=5, bin_in=0 -> bcd_out=20'h00000, overflow=0, out_valid exactly 16 cycles after acceptance.
- bin_in=65535 -> bcd_out=20'h65535, overflow=0.
- bin_in=29 with out_ready held 0 for 5 cycles -> bcd_out=20'h00029 stable and out_valid=1 throughout; in_ready=0 until the cycle after out_ready=1.
- BIN_W=8, DIGITS=2, bin_in=255 -> bcd_out=8'h55, overflow=1. Then bin_in=99 -> bcd_out=8'h99, overflow=0 (overflow cleared per conversion).
- rst_n=0 at SHIFT cycle 7 -> next cycle in_ready=1, out_valid=0, bcd_out=0. A new conversion of 1234 then yields 20'h01234.
- BCD_SIGNED_EN, BIN_W=8, DIGITS=3:
  - bin_in=8'h80 -> sign_out=1, bcd_out=12'h128;
  - bin_in=8'hFF -> sign_out=1, bcd_out=12'h001;
  - bin_in=0 -> sign_out=0.
